// File: rtl/timer_prescaler_if.sv
// Register-file <-> prescaler connection: control inputs plus the
// tick, divided clock and selection status returned to the timer core.
interface timer_prescaler_if #(
    parameter int SEL_W = 3
) ();
    logic             sc_en;
    logic             sc_halt;
    logic             sc_clr;
    logic [SEL_W-1:0] sc_cks;
    logic             pre_tick;
    logic             pre_div_clk;
    logic [SEL_W-1:0] pre_cks_act;
    logic             pre_pend;

    // Register-file / test side: drives the controls and observes the outputs.
    modport master (
        output sc_en, sc_halt, sc_clr, sc_cks,
        input  pre_tick, pre_div_clk, pre_cks_act, pre_pend
    );

    // Prescaler side.
    modport slave (
        input  sc_en, sc_halt, sc_clr, sc_cks,
        output pre_tick, pre_div_clk, pre_cks_act, pre_pend
    );
endinterface

// File: rtl/timer_prescaler.sv
// Synchronous power-of-two prescaler: a single counter in the sc_clk domain
// produces a one-cycle tick and a registered 50% divided clock. The ratio is
// 2^min(sel+1, CNT_W). Selection changes are taken only at the period wrap,
// so the divided clock never shows a runt pulse.
module timer_prescaler #(
    parameter int CNT_W = 8,
    parameter int SEL_W = 3
) (
    input  logic              sc_clk,
    input  logic              sc_reset_n,
    timer_prescaler_if.slave  bus
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             tick_reg;
    logic             tick_next;
    logic             div_reg;
    logic             div_next;
    logic [SEL_W-1:0] cks_act_reg;
    logic [SEL_W-1:0] cks_act_next;

    // Bits of the counter in use for the active ratio (all ones at N-1),
    // and a one-hot pointer at the top used bit (k-1) for the divided clock.
    logic [CNT_W-1:0] period_mask;
    logic [CNT_W-1:0] msb_sel;
    logic             wrap;
    logic             advance;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_mask
            // Bit gi is in use when gi < k, i.e. gi <= selection; larger
            // selections simply use every bit, which gives the clamp.
            assign period_mask[gi] = (int'(cks_act_reg) >= gi);
            if (gi == CNT_W - 1) begin : g_top
                assign msb_sel[gi] = period_mask[gi];
            end else begin : g_mid
                assign msb_sel[gi] = period_mask[gi] & ~period_mask[gi+1];
            end
        end
    endgenerate

    assign wrap    = (cnt_reg == period_mask);
    assign advance = bus.sc_en & ~bus.sc_halt & ~bus.sc_clr;

    // Next-state selection: clear/idle, then halt, then advance with wrap.
    always_comb begin
        cnt_next     = cnt_reg;
        tick_next    = 1'b0;
        div_next     = div_reg;
        cks_act_next = cks_act_reg;
        if (bus.sc_clr || !bus.sc_en) begin
            cnt_next     = '0;
            div_next     = 1'b0;
            cks_act_next = bus.sc_cks;
        end else if (bus.sc_halt) begin
            // Freeze: counter, divided clock and selection hold.
            cnt_next = cnt_reg;
        end else if (advance) begin
            if (wrap) begin
                cnt_next     = '0;
                tick_next    = 1'b1;
                cks_act_next = bus.sc_cks;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            // Divided clock follows bit k-1 of the new count; after a wrap
            // the count is zero so the new ratio always starts low.
            div_next = |(cnt_next & msb_sel);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sc_clk or negedge sc_reset_n) begin
        if (!sc_reset_n) begin
            cnt_reg     <= '0;
            tick_reg    <= 1'b0;
            div_reg     <= 1'b0;
            cks_act_reg <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            tick_reg    <= tick_next;
            div_reg     <= div_next;
            cks_act_reg <= cks_act_next;
        end
    end

    assign bus.pre_tick    = tick_reg;
    assign bus.pre_div_clk = div_reg;
    assign bus.pre_cks_act = cks_act_reg;
    assign bus.pre_pend    = (bus.sc_cks != cks_act_reg);

endmodule

// File: tb/tb_timer_prescaler.sv
// Self-checking bench for timer_prescaler: two instances (CNT_W=8 and
// CNT_W=4) share one stimulus stream and are compared every cycle against
// a period/phase reference model.
module tb_timer_prescaler;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       halt;
    logic       clr;
    logic [2:0] cks;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state per instance: phase within period, active select.
    int m_p[2];
    int m_act[2];
    int m_tick[2];
    int m_div[2];
    int cnt_w[2];

    timer_prescaler_if #(.SEL_W(3)) if8 ();
    timer_prescaler_if #(.SEL_W(3)) if4 ();

    assign if8.sc_en   = en;
    assign if8.sc_halt = halt;
    assign if8.sc_clr  = clr;
    assign if8.sc_cks  = cks;
    assign if4.sc_en   = en;
    assign if4.sc_halt = halt;
    assign if4.sc_clr  = clr;
    assign if4.sc_cks  = cks;

    timer_prescaler #(.CNT_W(8), .SEL_W(3)) dut8 (
        .sc_clk     (clk),
        .sc_reset_n (rst_n),
        .bus        (if8)
    );

    timer_prescaler #(.CNT_W(4), .SEL_W(3)) dut4 (
        .sc_clk     (clk),
        .sc_reset_n (rst_n),
        .bus        (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ratio(int d);
        int k;
        k = (m_act[d] + 1 < cnt_w[d]) ? m_act[d] + 1 : cnt_w[d];
        return 1 << k;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_p[d] = 0; m_act[d] = 0; m_tick[d] = 0; m_div[d] = 0;
        end
    endtask

    // One sc_clk edge of the reference, using the inputs held across the edge.
    task automatic model_step(int d);
        int n;
        n = ratio(d);
        if (!en || clr) begin
            m_p[d] = 0; m_tick[d] = 0; m_div[d] = 0; m_act[d] = int'(cks);
        end else if (halt) begin
            m_tick[d] = 0;
        end else begin
            m_p[d] = m_p[d] + 1;
            if (m_p[d] == n) begin
                m_p[d] = 0; m_tick[d] = 1; m_act[d] = int'(cks);
            end else begin
                m_tick[d] = 0;
            end
            m_div[d] = (m_p[d] >= n / 2) ? 1 : 0;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("tick8", 32'(if8.pre_tick),    32'(m_tick[0]));
        check("div8",  32'(if8.pre_div_clk), 32'(m_div[0]));
        check("act8",  32'(if8.pre_cks_act), 32'(m_act[0]));
        check("pend8", 32'(if8.pre_pend),    32'(int'(cks) != m_act[0]));
        check("tick4", 32'(if4.pre_tick),    32'(m_tick[1]));
        check("div4",  32'(if4.pre_div_clk), 32'(m_div[1]));
        check("act4",  32'(if4.pre_cks_act), 32'(m_act[1]));
        check("pend4", 32'(if4.pre_pend),    32'(int'(cks) != m_act[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the 8-bit instance reaches the given phase (bounded).
    task automatic wait_phase(int target);
        int found;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_p[0] == target) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("wait_phase", 32'(found), 32'(1));
    endtask

    initial begin
        cnt_w[0] = 8;
        cnt_w[1] = 4;
        rst_n = 1'b0; en = 1'b1; halt = 1'b0; clr = 1'b0; cks = 3'd0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // N=2: ticks after edges 2,4,6, divided clock toggles every cycle.
        run(8);

        // N=8, then a deferred switch back to N=2 requested at cnt=3.
        cks = 3'd2;
        run(4);
        wait_phase(3);
        cks = 3'd0;
        run(16);

        // Largest select: 256 on CNT_W=8, clamped to 16 on CNT_W=4.
        cks = 3'd7;
        run(530);

        // N=4 with a 5-cycle halt at cnt=2.
        cks = 3'd1;
        run(260);
        wait_phase(2);
        halt = 1'b1;
        run(5);
        halt = 1'b0;
        run(12);

        // N=8 with a clear pulse at cnt=5.
        cks = 3'd2;
        run(8);
        wait_phase(5);
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        run(12);

        // Idle for 3 cycles while the selection moves to 3 (N=16).
        en = 1'b0;
        cks = 3'd3;
        run(3);
        en = 1'b1;
        run(20);

        // Randomised mix of enable, halt, clear and selection changes.
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 15) != 0);
            halt = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 9) == 0) cks = 3'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset mid-period, observed before any further edge.
        en = 1'b1; halt = 1'b0; clr = 1'b0; cks = 3'd2;
        run(13);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        rst_n = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
